// File: rtl/credit_counter_multi.sv
// Multi-channel credit counter: multi-credit give/take per cycle, non-underflowing
// take handshake, saturating give with sticky overflow, and an aggregate count.
module credit_counter_multi #(
  parameter int unsigned NumChannels     = 4,
  parameter int unsigned NumCredits      = 8,
  parameter int unsigned MaxDelta        = 1,
  parameter bit          InitCreditEmpty = 1'b0,
  parameter int unsigned CritMargin      = 1,
  localparam int unsigned CntW           = $clog2(NumCredits) + 1,
  localparam int unsigned DeltaW         = $clog2(MaxDelta) + 1,
  localparam int unsigned TotalW         = $clog2(NumChannels * NumCredits) + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumChannels-1:0]              credit_init_i,
  input  logic [NumChannels-1:0][DeltaW-1:0]  credit_give_i,
  input  logic [NumChannels-1:0]              take_valid_i,
  input  logic [NumChannels-1:0][DeltaW-1:0]  take_amt_i,
  output logic [NumChannels-1:0]              take_ready_o,
  output logic [NumChannels-1:0][CntW-1:0]    credit_o,
  output logic [TotalW-1:0]                   credit_total_o,
  output logic [NumChannels-1:0]              credit_left_o,
  output logic [NumChannels-1:0]              credit_crit_o,
  output logic [NumChannels-1:0]              credit_full_o,
  output logic [NumChannels-1:0]              overflow_o
);

  localparam int unsigned     TmpW    = CntW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(NumCredits);
  localparam logic [CntW-1:0] InitCnt = InitCreditEmpty ? {CntW{1'b0}} : FullCnt;
  localparam logic [CntW-1:0] CritCnt = CntW'(NumCredits - CritMargin);

  logic [NumChannels-1:0][CntW-1:0] credit_r, credit_s;
  logic [NumChannels-1:0]           overflow_r, overflow_s, take_fire_s;
  logic [NumChannels-1:0][TmpW-1:0] tmp_s;
  logic [TotalW-1:0]                total_s;

  // Take handshake and next-state; the take check sees only the registered count.
  always_comb begin
    take_ready_o = {NumChannels{1'b0}};
    take_fire_s  = {NumChannels{1'b0}};
    tmp_s        = {(NumChannels*TmpW){1'b0}};
    credit_s     = credit_r;
    overflow_s   = overflow_r;
    for (int i = 0; i < NumChannels; i++) begin
      take_ready_o[i] = ~credit_init_i[i] & (credit_r[i] >= CntW'(take_amt_i[i]));
      take_fire_s[i]  = take_valid_i[i] & take_ready_o[i];
      tmp_s[i] = TmpW'(credit_r[i]) + TmpW'(credit_give_i[i])
               - (take_fire_s[i] ? TmpW'(take_amt_i[i]) : {TmpW{1'b0}});
      if (credit_init_i[i]) begin
        credit_s[i]   = InitCnt;
        overflow_s[i] = 1'b0;
      end else if (tmp_s[i] > TmpW'(FullCnt)) begin
        credit_s[i]   = FullCnt;
        overflow_s[i] = 1'b1;
      end else begin
        credit_s[i]   = tmp_s[i][CntW-1:0];
        overflow_s[i] = overflow_r[i];
      end
    end
  end

  // Per-channel count and sticky overflow registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_r   <= {NumChannels{InitCnt}};
      overflow_r <= {NumChannels{1'b0}};
    end else begin
      credit_r   <= credit_s;
      overflow_r <= overflow_s;
    end
  end

  // Status decode and pool-level sum of the registered counts.
  always_comb begin
    total_s       = {TotalW{1'b0}};
    credit_left_o = {NumChannels{1'b0}};
    credit_crit_o = {NumChannels{1'b0}};
    credit_full_o = {NumChannels{1'b0}};
    for (int i = 0; i < NumChannels; i++) begin
      credit_left_o[i] = (credit_r[i] != {CntW{1'b0}});
      credit_crit_o[i] = (credit_r[i] >= CritCnt);
      credit_full_o[i] = (credit_r[i] == FullCnt);
      total_s          = total_s + TotalW'(credit_r[i]);
    end
  end

  assign credit_o       = credit_r;
  assign overflow_o     = overflow_r;
  assign credit_total_o = total_s;

  credit_counter_multi_chk #(
    .NumChannels (NumChannels),
    .NumCredits  (NumCredits),
    .MaxDelta    (MaxDelta)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .credit_give_i (credit_give_i),
    .take_valid_i  (take_valid_i),
    .take_amt_i    (take_amt_i),
    .take_ready_i  (take_ready_o),
    .credit_i      (credit_r)
  );

endmodule

// Protocol and invariant properties for credit_counter_multi.
module credit_counter_multi_chk #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned NumCredits  = 8,
  parameter int unsigned MaxDelta    = 1,
  localparam int unsigned CntW       = $clog2(NumCredits) + 1,
  localparam int unsigned DeltaW     = $clog2(MaxDelta) + 1
) (
  input logic                               clk_i,
  input logic                               rst_ni,
  input logic [NumChannels-1:0][DeltaW-1:0] credit_give_i,
  input logic [NumChannels-1:0]             take_valid_i,
  input logic [NumChannels-1:0][DeltaW-1:0] take_amt_i,
  input logic [NumChannels-1:0]             take_ready_i,
  input logic [NumChannels-1:0][CntW-1:0]   credit_i
);

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    give_max_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      credit_give_i[g] <= DeltaW'(MaxDelta));
    take_max_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      take_amt_i[g] <= DeltaW'(MaxDelta));
    take_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (take_valid_i[g] && !take_ready_i[g]) ##1 take_valid_i[g] |-> $stable(take_amt_i[g]))
      else $warning("take_amt changed while a take request was stalled");
    cap_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      credit_i[g] <= CntW'(NumCredits));
  end

endmodule

// File: tb/tb_credit_counter_multi.sv
// Directed bench for credit_counter_multi with a per-cycle behavioural model.
module tb_credit_counter_multi;

  localparam int NCH  = 4;
  localparam int NCR  = 8;
  localparam int MD   = 4;
  localparam int CM   = 1;
  localparam bit ICE  = 1'b0;
  localparam int INIT = ICE ? 0 : NCR;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic [3:0]       init_v, valid_v, ready_v, left_v, crit_v, full_v, ovf_v;
  logic [3:0][2:0]  give_v, amt_v;
  logic [3:0][3:0]  credit_v;
  logic [5:0]       total_v;

  int checks = 0;
  int errors = 0;
  int m_cnt [NCH] = '{default: INIT};
  bit m_ovf [NCH] = '{default: 1'b0};

  credit_counter_multi #(
    .NumChannels(NCH), .NumCredits(NCR), .MaxDelta(MD),
    .InitCreditEmpty(ICE), .CritMargin(CM)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .credit_init_i(init_v), .credit_give_i(give_v),
    .take_valid_i(valid_v), .take_amt_i(amt_v), .take_ready_o(ready_v),
    .credit_o(credit_v), .credit_total_o(total_v),
    .credit_left_o(left_v), .credit_crit_o(crit_v), .credit_full_o(full_v),
    .overflow_o(ovf_v)
  );

  always #5 clk = ~clk;

  function automatic int net(int c, int g, bit v, int a);
    return c + g - ((v && c >= a) ? a : 0);
  endfunction

  // Reference model: count saturates at capacity, overflow is sticky until init/reset.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] <= INIT;
        m_ovf[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (init_v[i]) begin
          m_cnt[i] <= INIT;
          m_ovf[i] <= 1'b0;
        end else begin
          m_cnt[i] <= (net(m_cnt[i], int'(give_v[i]), valid_v[i], int'(amt_v[i])) > NCR)
                      ? NCR : net(m_cnt[i], int'(give_v[i]), valid_v[i], int'(amt_v[i]));
          m_ovf[i] <= m_ovf[i] | (net(m_cnt[i], int'(give_v[i]), valid_v[i], int'(amt_v[i])) > NCR);
        end
      end
    end
  end

  task automatic cmp(string name, int ch, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0d expected %0d at %0t", name, ch, got, exp, $time);
    end
  endtask

  // Compare every output against the model mid-cycle, when inputs and state are stable.
  always @(negedge clk) begin
    int sum;
    sum = 0;
    for (int i = 0; i < NCH; i++) begin
      sum += m_cnt[i];
      cmp("credit", i, int'(credit_v[i]), m_cnt[i]);
      cmp("ready", i, int'(ready_v[i]), int'(!init_v[i] && m_cnt[i] >= int'(amt_v[i])));
      cmp("left", i, int'(left_v[i]), int'(m_cnt[i] != 0));
      cmp("crit", i, int'(crit_v[i]), int'(m_cnt[i] >= NCR - CM));
      cmp("full", i, int'(full_v[i]), int'(m_cnt[i] == NCR));
      cmp("overflow", i, int'(ovf_v[i]), int'(m_ovf[i]));
    end
    cmp("total", 0, int'(total_v), sum);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    init_v = '0; give_v = '0; valid_v = '0; amt_v = '0;
  endtask

  initial begin
    clear();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NCH; i++) cmp("rst_credit_lit", i, int'(credit_v[i]), 8);
    cmp("rst_total_lit", 0, int'(total_v), 32);
    cmp("rst_full_lit", 0, int'(full_v), 15);
    cmp("rst_crit_lit", 0, int'(crit_v), 15);
    cmp("rst_ovf_lit", 0, int'(ovf_v), 0);
    cmp("rst_ready_lit", 0, int'(ready_v), 15);
    #2 rst_ni = 1'b1;

    // Channel 0: back-to-back takes, a refused take, then drain to zero.
    step(); valid_v[0] = 1'b1; amt_v[0] = 3'd3;
    @(negedge clk); cmp("ch0_ready3_lit", 0, int'(ready_v[0]), 1);
    step(); amt_v[0] = 3'd4;
    @(negedge clk); cmp("ch0_after3_lit", 0, int'(credit_v[0]), 5);
    step(); valid_v[0] = 1'b0; amt_v[0] = 3'd0;
    @(negedge clk); cmp("ch0_after4_lit", 0, int'(credit_v[0]), 1);
    step(); valid_v[0] = 1'b1; amt_v[0] = 3'd2;
    @(negedge clk); cmp("ch0_refuse_lit", 0, int'(ready_v[0]), 0);
    step(); valid_v[0] = 1'b0; amt_v[0] = 3'd0;
    @(negedge clk); cmp("ch0_hold_lit", 0, int'(credit_v[0]), 1);
    step(); valid_v[0] = 1'b1; amt_v[0] = 3'd1;
    @(negedge clk); cmp("ch0_ready1_lit", 0, int'(ready_v[0]), 1);
    step(); clear();
    @(negedge clk); cmp("ch0_empty_lit", 0, int'(credit_v[0]), 0);
    cmp("ch0_left_lit", 0, int'(left_v[0]), 0);

    // Channel 1: net give/take reaching capacity, then a saturating give.
    step(); valid_v[1] = 1'b1; amt_v[1] = 3'd2;
    step(); give_v[1] = 3'd4;
    @(negedge clk); cmp("ch1_six_lit", 1, int'(credit_v[1]), 6);
    step(); clear(); give_v[1] = 3'd1;
    @(negedge clk); cmp("ch1_net8_lit", 1, int'(credit_v[1]), 8);
    cmp("ch1_noovf_lit", 1, int'(ovf_v[1]), 0);
    step(); clear();
    @(negedge clk); cmp("ch1_sat_lit", 1, int'(credit_v[1]), 8);
    cmp("ch1_ovf_lit", 1, int'(ovf_v[1]), 1);
    step();
    @(negedge clk); cmp("ch1_sticky_lit", 1, int'(ovf_v[1]), 1);

    // Channel 2: a same-cycle give never enables a take from zero.
    step(); valid_v[2] = 1'b1; amt_v[2] = 3'd4;
    step();
    step(); give_v[2] = 3'd3; amt_v[2] = 3'd2;
    @(negedge clk); cmp("ch2_zero_lit", 2, int'(credit_v[2]), 0);
    cmp("ch2_noready_lit", 2, int'(ready_v[2]), 0);
    step(); clear();
    @(negedge clk); cmp("ch2_three_lit", 2, int'(credit_v[2]), 3);

    // Channel 1 init overrides give and a pending take; other channels untouched.
    step(); init_v[1] = 1'b1; give_v[1] = 3'd2; valid_v[1] = 1'b1; amt_v[1] = 3'd1;
    @(negedge clk); cmp("ch1_init_ready_lit", 1, int'(ready_v[1]), 0);
    step(); clear();
    @(negedge clk); cmp("ch1_init_cnt_lit", 1, int'(credit_v[1]), 8);
    cmp("ch1_init_ovf_lit", 1, int'(ovf_v[1]), 0);
    cmp("ch0_iso_lit", 0, int'(credit_v[0]), 0);
    cmp("ch2_iso_lit", 2, int'(credit_v[2]), 3);
    cmp("ch3_iso_lit", 3, int'(credit_v[3]), 8);

    // Build mixed counts {0,5,8,3}, overflowing channel 2 on the way.
    step(); valid_v[1] = 1'b1; amt_v[1] = 3'd3; valid_v[3] = 1'b1; amt_v[3] = 3'd4; give_v[2] = 3'd4;
    step(); valid_v[1] = 1'b0; amt_v[1] = 3'd0; amt_v[3] = 3'd1; give_v[2] = 3'd2;
    step(); clear();
    @(negedge clk);
    cmp("mix0_lit", 0, int'(credit_v[0]), 0);
    cmp("mix1_lit", 1, int'(credit_v[1]), 5);
    cmp("mix2_lit", 2, int'(credit_v[2]), 8);
    cmp("mix3_lit", 3, int'(credit_v[3]), 3);
    cmp("mix_ovf_lit", 0, int'(ovf_v), 4);
    cmp("mix_total_lit", 0, int'(total_v), 16);

    // Asynchronous reset mid-cycle with traffic in flight.
    step(); give_v[0] = 3'd2; valid_v[3] = 1'b1; amt_v[3] = 3'd1;
    #2 rst_ni = 1'b0;
    #1;
    for (int i = 0; i < NCH; i++) cmp("arst_credit_lit", i, int'(credit_v[i]), 8);
    cmp("arst_ovf_lit", 0, int'(ovf_v), 0);
    cmp("arst_total_lit", 0, int'(total_v), 32);
    repeat (2) @(negedge clk);
    clear();
    #2 rst_ni = 1'b1;

    // Mixed traffic on all channels, checked by the model each cycle.
    for (int n = 0; n < 80; n++) begin
      step();
      for (int i = 0; i < NCH; i++) begin
        init_v[i] = ($urandom_range(15) == 0);
        give_v[i] = 3'($urandom_range(MD));
        amt_v[i]  = 3'($urandom_range(MD));
        valid_v[i] = valid_v[i] ? 1'b0 : 1'($urandom_range(1));
      end
    end
    step(); clear();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
